// File: rtl/pipeline_pkg.sv
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared encodings and constants for the pipeline hazard
//               sequencer (FSM state encoding, register-index width).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

  // Width of an architectural register index (x0..x31)
  localparam int REG_IDX_W = 5;

  // Register x0 is hard-wired to zero and never creates a dependency
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  // Memory-wait counter width; wide enough for the largest legal timeout (255)
  localparam int WAIT_W = 8;

  // Hazard sequencer states
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } hz_state_t;

endpackage

`default_nettype wire

// File: rtl/hazard_load_use_detect.sv
// ============================================================================
// Module      : hazard_load_use_detect
// Description : Combinational load-use comparator. Flags an ID instruction
//               that reads the destination of a load currently in EX, which
//               forwarding cannot cover.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_load_use_detect
  import pipeline_pkg::*;
(
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  output logic                 load_use
);

  // A load into x0 never produces a value, so it cannot be a hazard source
  always_comb begin
    load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                (id_uses_rs2 && (id_rs2 == ex_rd)));
  end

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush sequencer for the 5-stage RV64 pipeline.
//               Priority: memory wait > taken-branch flush > load-use stall.
//               A watchdog moves to a sticky ERR state when a data-memory
//               access waits MEM_TIMEOUT cycles without mem_ready.
//               Optional: define HAZARD_PERF_CNT_EN to build the stall/flush
//               performance counters; otherwise both outputs read 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  input  logic                 branch_taken,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 if_id_flush,
  output logic                 id_ex_write,
  output logic                 id_ex_flush,
  output logic                 ex_mem_write,
  output logic                 ex_mem_flush,
  output logic                 mem_wb_flush,
  output logic                 mem_timeout,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(MEM_TIMEOUT);

  hz_state_t         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q;
  logic              load_use;

  hazard_load_use_detect u_lu_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .load_use    (load_use)
  );

  // Next-state and stage controls; a freeze also bubbles MEM/WB so the
  // stalled access is not written back repeatedly. Reset forces all idle.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;

    case (state_q)
      RUN, MEM_WAIT: begin
        if (!mem_ready && (mem_req || (state_q == MEM_WAIT))) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_write  = 1'b0;
          ex_mem_write = 1'b0;
          mem_wb_flush = 1'b1;
          wait_cnt_d   = (state_q == RUN) ? WAIT_W'(1) : wait_cnt_q + WAIT_W'(1);
          state_d      = (wait_cnt_d == TIMEOUT_C) ? ERR : MEM_WAIT;
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
          if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
      end
      default: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
        mem_wb_flush = 1'b1;
      end
    endcase

    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_write  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_write = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;
    end
  end

  // Sequencer state, wait counter and sticky watchdog flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (state_d == ERR) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign mem_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Stall cycles are any PC hold outside ERR; if_id_flush only fires on a taken branch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_write && (state_q != ERR)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (if_id_flush) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

`default_nettype wire
